// File: rtl/imem_responder.sv
// Instruction-memory responder: 1-cycle fetch read port plus a byte-serial program
// loader that fills the word memory and stalls fetch while it runs.
module imem_responder #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH_LOG2 = 10,
    parameter logic [WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR  = WIDTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] nextinstrdata,
    output logic             fetch_valid,
    output logic             imem_stall,
    output logic             fetch_fault,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [7:0]       load_byte,
    output logic             load_ready,
    input  logic             load_end,
    output logic             load_done,
    output logic             load_overflow
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_bytecnt, w_bytecnt_nxt;
    logic [AW:0]      r_waddr, w_waddr_nxt;
    logic [WIDTH-1:0] r_wbuf, w_wbuf_nxt;
    logic             r_end_pend, w_end_pend_nxt;
    logic             r_load_overflow, w_load_overflow_nxt;
    logic             r_load_done, w_load_done_nxt;
    logic             r_load_ready, w_load_ready_nxt;
    logic             r_fetch_valid, w_fetch_valid_nxt;
    logic             r_fetch_fault, w_fetch_fault_nxt;
    logic             r_imem_stall, w_imem_stall_nxt;
    logic [WIDTH-1:0] r_nextinstr, w_nextinstr_nxt;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_mem_we;

    logic [WIDTH-1:0] w_idx;
    logic             w_addr_fault;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_take;

    // Fetch address decode: misaligned, below base, or past the last word
    always_comb begin
        w_idx        = (pc - BASE_ADDR) >> 2;
        w_addr_fault = (pc[1:0] != 2'b00) || (pc < BASE_ADDR) || ((w_idx >> DEPTH_LOG2) != '0);
        w_rd_data    = r_mem[w_idx[AW-1:0]];
    end

    assign w_take = load_valid && r_load_ready;

    // Next-state, loader datapath and fetch outputs
    always_comb begin
        w_state_nxt         = r_state;
        w_bytecnt_nxt       = r_bytecnt;
        w_waddr_nxt         = r_waddr;
        w_wbuf_nxt          = r_wbuf;
        w_end_pend_nxt      = r_end_pend;
        w_load_overflow_nxt = r_load_overflow;
        w_load_done_nxt     = 1'b0;
        w_mem_we            = 1'b0;
        w_fetch_valid_nxt   = 1'b0;
        w_fetch_fault_nxt   = 1'b0;
        w_nextinstr_nxt     = NOP_INSTR;

        if (r_state == S_IDLE) begin
            w_fetch_valid_nxt = 1'b1;
            w_fetch_fault_nxt = w_addr_fault;
            w_nextinstr_nxt   = w_addr_fault ? NOP_INSTR : w_rd_data;
        end

        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_nxt         = S_LOAD;
                    w_bytecnt_nxt       = 2'd0;
                    w_waddr_nxt         = '0;
                    w_wbuf_nxt          = '0;
                    w_end_pend_nxt      = 1'b0;
                    w_load_overflow_nxt = 1'b0;
                end
            end
            S_LOAD: begin
                if (w_take) begin
                    w_wbuf_nxt[{r_bytecnt, 3'b000} +: 8] = load_byte;
                    w_bytecnt_nxt = r_bytecnt + 2'd1;
                end
                // A byte arriving with load_end is absorbed before the end is handled
                if (w_take && (r_bytecnt == 2'd3)) begin
                    w_state_nxt    = S_COMMIT;
                    w_end_pend_nxt = load_end;
                end else if (load_end) begin
                    if (w_bytecnt_nxt != 2'd0) begin
                        w_state_nxt    = S_COMMIT;
                        w_end_pend_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = S_IDLE;
                        w_load_done_nxt = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                if (r_waddr[AW]) begin
                    w_load_overflow_nxt = 1'b1;
                end else begin
                    w_mem_we    = 1'b1;
                    w_waddr_nxt = r_waddr + (AW+1)'(1);
                end
                w_wbuf_nxt      = '0;
                w_bytecnt_nxt   = 2'd0;
                w_end_pend_nxt  = 1'b0;
                w_load_done_nxt = r_end_pend;
                w_state_nxt     = r_end_pend ? S_IDLE : S_LOAD;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_load_ready_nxt = (w_state_nxt == S_LOAD);
        w_imem_stall_nxt = (w_state_nxt != S_IDLE) || !w_fetch_valid_nxt;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_bytecnt       <= 2'd0;
            r_waddr         <= '0;
            r_wbuf          <= '0;
            r_end_pend      <= 1'b0;
            r_load_overflow <= 1'b0;
            r_load_done     <= 1'b0;
            r_load_ready    <= 1'b0;
            r_fetch_valid   <= 1'b0;
            r_fetch_fault   <= 1'b0;
            r_imem_stall    <= 1'b1;
            r_nextinstr     <= NOP_INSTR;
        end else begin
            r_state         <= w_state_nxt;
            r_bytecnt       <= w_bytecnt_nxt;
            r_waddr         <= w_waddr_nxt;
            r_wbuf          <= w_wbuf_nxt;
            r_end_pend      <= w_end_pend_nxt;
            r_load_overflow <= w_load_overflow_nxt;
            r_load_done     <= w_load_done_nxt;
            r_load_ready    <= w_load_ready_nxt;
            r_fetch_valid   <= w_fetch_valid_nxt;
            r_fetch_fault   <= w_fetch_fault_nxt;
            r_imem_stall    <= w_imem_stall_nxt;
            r_nextinstr     <= w_nextinstr_nxt;
        end
    end

    // Word memory; contents survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_waddr[AW-1:0]] <= r_wbuf;
        end
    end

    assign nextinstrdata = r_nextinstr;
    assign fetch_valid   = r_fetch_valid;
    assign fetch_fault   = r_fetch_fault;
    assign imem_stall    = r_imem_stall;
    assign load_ready    = r_load_ready;
    assign load_done     = r_load_done;
    assign load_overflow = r_load_overflow;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: a 1024-word instance and a 4-word
// instance share all inputs; fetch expectations flow through a scoreboard queue.
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = '0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = '0;
    logic        load_end = 1'b0;

    logic [31:0] nextinstrdata, s_nextinstrdata;
    logic        fetch_valid, s_fetch_valid;
    logic        imem_stall, s_imem_stall;
    logic        fetch_fault, s_fetch_fault;
    logic        load_ready, s_load_ready;
    logic        load_done, s_load_done;
    logic        load_overflow, s_load_overflow;

    imem_responder u_dut (
        .clk(clk), .reset(reset), .pc(pc),
        .nextinstrdata(nextinstrdata), .fetch_valid(fetch_valid),
        .imem_stall(imem_stall), .fetch_fault(fetch_fault),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(load_ready), .load_end(load_end), .load_done(load_done),
        .load_overflow(load_overflow)
    );

    imem_responder #(.DEPTH_LOG2(2)) u_small (
        .clk(clk), .reset(reset), .pc(pc),
        .nextinstrdata(s_nextinstrdata), .fetch_valid(s_fetch_valid),
        .imem_stall(s_imem_stall), .fetch_fault(s_fetch_fault),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(s_load_ready), .load_end(load_end), .load_done(s_load_done),
        .load_overflow(s_load_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  bq[$];
    int          checks = 0;
    int          failures = 0;
    int          tmo = 0;
    int          pulses = 0;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] a, input logic [31:0] d, input logic f);
        pc = a;
        exp_q.push_back('{data: d, fault: f});
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_bytes(input bit end_with_last);
        for (int i = 0; i < bq.size(); i++) begin
            int w = 0;
            while (!load_ready && w < 20) begin tick(); w++; end
            if (!load_ready) tmo++;
            load_valid = 1'b1;
            load_byte  = bq[i];
            load_end   = end_with_last && (i == bq.size() - 1);
            tick();
            load_valid = 1'b0;
            load_end   = 1'b0;
        end
        bq.delete();
    endtask

    task automatic end_load();
        int w = 0;
        while (!load_ready && w < 20) begin tick(); w++; end
        if (!load_ready) tmo++;
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    task automatic wait_done();
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (load_done) pulses++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++;
        if (nextinstrdata !== NOP || fetch_valid !== 1'b0 || imem_stall !== 1'b1 || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_fetch: got data=%h v=%b st=%b f=%b exp data=%h v=0 st=1 f=0",
                     nextinstrdata, fetch_valid, imem_stall, fetch_fault, NOP);
        end
        checks++;
        if (load_ready !== 1'b0 || load_done !== 1'b0 || load_overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_load: got rdy=%b done=%b ovf=%b exp 0 0 0", load_ready, load_done, load_overflow);
        end
        reset = 1'b1;
        pc = 32'h0;
        tick();
        checks++;
        if (fetch_valid !== 1'b1 || imem_stall !== 1'b0 || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got v=%b st=%b f=%b exp v=1 st=0 f=0", fetch_valid, imem_stall, fetch_fault);
        end
    endtask

    task automatic test_load();
        exp_t e;
        logic [31:0] words [2];
        words[0] = 32'h00A0_0513;
        words[1] = 32'h0010_0593;
        tmo = 0;
        start_load();
        tick();
        checks++;
        if (fetch_valid !== 1'b0 || imem_stall !== 1'b1 || nextinstrdata !== NOP || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_stall: got v=%b st=%b data=%h rdy=%b exp v=0 st=1 data=%h rdy=1",
                     fetch_valid, imem_stall, nextinstrdata, load_ready, NOP);
        end
        bq = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        send_bytes(1'b0);
        end_load();
        wait_done();
        checks++;
        if (pulses !== 1 || tmo !== 0) begin
            failures++;
            $display("FAIL load_done: got pulses=%0d timeouts=%0d exp pulses=1 timeouts=0", pulses, tmo);
        end
        for (int i = 0; i < 2; i++) begin
            push_fetch(32'(4 * i), words[i], 1'b0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (nextinstrdata !== e.data || fetch_fault !== e.fault || fetch_valid !== 1'b1) begin
                failures++;
                $display("FAIL load_fetch%0d: got data=%h f=%b v=%b exp data=%h f=%b v=1",
                         i, nextinstrdata, fetch_fault, fetch_valid, e.data, e.fault);
            end
        end
    endtask

    task automatic test_partial();
        exp_t e;
        tmo = 0;
        start_load();
        bq = '{8'h37, 8'h12, 8'h00};
        send_bytes(1'b1);
        wait_done();
        checks++;
        if (pulses !== 1 || tmo !== 0 || imem_stall !== 1'b0) begin
            failures++;
            $display("FAIL partial_done: got pulses=%0d timeouts=%0d st=%b exp 1 0 0", pulses, tmo, imem_stall);
        end
        push_fetch(32'h0, 32'h0000_1237, 1'b0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (nextinstrdata !== e.data || fetch_fault !== e.fault) begin
            failures++;
            $display("FAIL partial_word: got data=%h f=%b exp data=%h f=%b", nextinstrdata, fetch_fault, e.data, e.fault);
        end
    endtask

    task automatic test_faults();
        exp_t e;
        logic [31:0] addrs [6];
        tmo = 0;
        start_load();
        for (int i = 0; i < 1024; i++) push_word(pat(i));
        send_bytes(1'b0);
        end_load();
        wait_done();
        checks++;
        if (pulses !== 1 || tmo !== 0 || load_overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_load: got pulses=%0d timeouts=%0d ovf=%b exp 1 0 0", pulses, tmo, load_overflow);
        end
        addrs = '{32'h0000_0002, 32'h0000_1000, 32'h0000_0FFC, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0801};
        push_fetch(addrs[0], NOP, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (nextinstrdata !== e.data || fetch_fault !== e.fault || fetch_valid !== 1'b1) begin
                failures++;
                $display("FAIL fault_pc_%h: got data=%h f=%b v=%b exp data=%h f=%b v=1",
                         addrs[i], nextinstrdata, fetch_fault, fetch_valid, e.data, e.fault);
            end
            case (i)
                0: push_fetch(addrs[1], NOP, 1'b1);
                1: push_fetch(addrs[2], pat(1023), 1'b0);
                2: push_fetch(addrs[3], pat(0), 1'b0);
                3: push_fetch(addrs[4], NOP, 1'b1);
                4: push_fetch(addrs[5], NOP, 1'b1);
                default: pc = 32'h0;
            endcase
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        logic [31:0] w [5];
        w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
        tmo = 0;
        start_load();
        checks++;
        if (s_load_overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear_on_start: got %b exp 0", s_load_overflow);
        end
        for (int i = 0; i < 5; i++) push_word(w[i]);
        send_bytes(1'b0);
        end_load();
        wait_done();
        checks++;
        if (s_load_overflow !== 1'b1 || load_overflow !== 1'b0 || tmo !== 0) begin
            failures++;
            $display("FAIL ovf_flag: got small=%b big=%b timeouts=%0d exp 1 0 0", s_load_overflow, load_overflow, tmo);
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_fetch(32'(4 * i), w[i], 1'b0);
            else push_fetch(32'h10, NOP, 1'b1);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (s_nextinstrdata !== e.data || s_fetch_fault !== e.fault || s_fetch_valid !== 1'b1) begin
                failures++;
                $display("FAIL ovf_fetch%0d: got data=%h f=%b v=%b exp data=%h f=%b v=1",
                         i, s_nextinstrdata, s_fetch_fault, s_fetch_valid, e.data, e.fault);
            end
        end
        checks++;
        if (s_load_overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got %b exp 1", s_load_overflow);
        end
    endtask

    task automatic test_reset_mid_load();
        exp_t e;
        tmo = 0;
        start_load();
        bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
        send_bytes(1'b0);
        reset = 1'b0;
        tick();
        checks++;
        if (load_ready !== 1'b0 || load_done !== 1'b0 || fetch_valid !== 1'b0 || imem_stall !== 1'b1 || tmo !== 0) begin
            failures++;
            $display("FAIL midload_reset: got rdy=%b done=%b v=%b st=%b timeouts=%0d exp 0 0 0 1 0",
                     load_ready, load_done, fetch_valid, imem_stall, tmo);
        end
        reset = 1'b1;
        push_fetch(32'h0, 32'h1234_5678, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (nextinstrdata !== e.data || fetch_fault !== e.fault || load_ready !== 1'b0 || imem_stall !== 1'b0) begin
                failures++;
                $display("FAIL midload_fetch%0d: got data=%h f=%b rdy=%b st=%b exp data=%h f=%b rdy=0 st=0",
                         i, nextinstrdata, fetch_fault, load_ready, imem_stall, e.data, e.fault);
            end
            if (i == 0) begin
                push_fetch(32'h4, 32'h2222_2222, 1'b0);
                tick();
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_partial();
        test_faults();
        test_overflow();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
